// File: rtl/dip_stim_sequencer_pkg.sv
// Shared types for the DIP/PB stimulus sequencer: FSM states, step-table entry and default widths.
package stim_pkg;
    localparam int N_DIPS_D = 16;
    localparam int N_PBS_D  = 3;
    localparam int DEPTH_D  = 8;
    localparam int HOLD_W_D = 16;

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    // Field widths track the package defaults; the sequencer parameters default to the same values.
    typedef struct packed {
        logic [N_DIPS_D-1:0] dip;
        logic [N_PBS_D-1:0]  pb;
        logic [HOLD_W_D-1:0] hold;
        logic [HOLD_W_D-1:0] gap;
        logic                con_en;
        logic [7:0]          con_byte;
    } step_t;

    function automatic logic [HOLD_W_D-1:0] hold_load(input logic [HOLD_W_D-1:0] h);
        return (h == '0) ? HOLD_W_D'(1) : h;
    endfunction
endpackage

// File: rtl/dip_stim_sequencer_if.sv
// Host/Wrapper-side signal bundle of the stimulus sequencer; slave = sequencer, master = host/consumer.
interface dip_stim_sequencer_if
    import stim_pkg::*;
#(
    parameter int N_DIPs = N_DIPS_D,
    parameter int N_PBs  = N_PBS_D,
    parameter int DEPTH  = DEPTH_D,
    parameter int HOLD_W = HOLD_W_D
);
    localparam int AW = $clog2(DEPTH);

    logic              START;
    logic              STOP;
    logic              LOOP;
    logic [AW-1:0]     LAST_STEP;
    logic              WR_EN;
    logic [AW-1:0]     WR_ADDR;
    logic [N_DIPs-1:0] WR_DIP;
    logic [N_PBs-1:0]  WR_PB;
    logic [HOLD_W-1:0] WR_HOLD;
    logic [HOLD_W-1:0] WR_GAP;
    logic              WR_CON_EN;
    logic [7:0]        WR_CON_BYTE;
    logic [N_DIPs-1:0] DIP;
    logic [N_PBs-1:0]  PB;
    logic [7:0]        CONSOLE_IN;
    logic              CONSOLE_IN_valid;
    logic              CONSOLE_IN_ack;
    logic              BUSY;
    logic              DONE;
    logic [AW-1:0]     STEP_IDX;

    modport master (
        output START, STOP, LOOP, LAST_STEP, WR_EN, WR_ADDR, WR_DIP, WR_PB,
               WR_HOLD, WR_GAP, WR_CON_EN, WR_CON_BYTE, CONSOLE_IN_ack,
        input  DIP, PB, CONSOLE_IN, CONSOLE_IN_valid, BUSY, DONE, STEP_IDX
    );

    modport slave (
        input  START, STOP, LOOP, LAST_STEP, WR_EN, WR_ADDR, WR_DIP, WR_PB,
               WR_HOLD, WR_GAP, WR_CON_EN, WR_CON_BYTE, CONSOLE_IN_ack,
        output DIP, PB, CONSOLE_IN, CONSOLE_IN_valid, BUSY, DONE, STEP_IDX
    );
endinterface

// File: rtl/dip_stim_sequencer_step_ram.sv
// Step table: DEPTH entries, one synchronous write port, one asynchronous read port.
module stim_step_ram
    import stim_pkg::*;
#(
    parameter int DEPTH = DEPTH_D,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  step_t         i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output step_t         o_rd_data
);
    step_t r_mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/dip_stim_sequencer.sv
// Replays the step table into DIP/PB with per-step hold and zero gap, plus optional console byte injection.
module dip_stim_sequencer
    import stim_pkg::*;
#(
    parameter int N_DIPs = N_DIPS_D,
    parameter int N_PBs  = N_PBS_D,
    parameter int DEPTH  = DEPTH_D,
    parameter int HOLD_W = HOLD_W_D
) (
    input  logic                 CLK,
    input  logic                 RESET,
    dip_stim_sequencer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    state_t            r_state;
    logic [AW-1:0]     r_idx;
    logic [AW-1:0]     r_last;
    logic              r_loop;
    logic [HOLD_W-1:0] r_cnt;
    logic [HOLD_W-1:0] r_gap;
    logic              r_con_en;
    logic              r_sent;
    logic [N_DIPs-1:0] r_dip;
    logic [N_PBs-1:0]  r_pb;
    logic [7:0]        r_con;
    logic              r_valid;
    logic              r_done;

    step_t             w_wr_step;
    step_t             w_step;
    logic              w_wr_en;
    logic [AW-1:0]     w_nidx;
    logic              w_at_last;
    logic              w_cnt_exp;
    logic              w_xfer;
    logic              w_con_ok;
    logic              w_advance;
    logic              w_enter;
    logic              w_finish;

    assign w_wr_step = '{dip: bus.WR_DIP, pb: bus.WR_PB, hold: bus.WR_HOLD, gap: bus.WR_GAP,
                         con_en: bus.WR_CON_EN, con_byte: bus.WR_CON_BYTE};
    assign w_wr_en   = bus.WR_EN && (r_state == IDLE);

    // The table is read at the index the sequencer is about to enter, so outputs register in one edge.
    assign w_at_last = (r_idx == r_last);
    assign w_nidx    = ((r_state == IDLE) || w_at_last) ? '0 : AW'(r_idx + 1'b1);

    assign w_cnt_exp = (r_cnt == HOLD_W'(1));
    assign w_xfer    = r_valid && bus.CONSOLE_IN_ack;
    assign w_con_ok  = !r_con_en || r_sent || w_xfer;
    assign w_advance = ((r_state == HOLD) && w_cnt_exp && w_con_ok && (r_gap == '0)) ||
                       ((r_state == GAP) && w_cnt_exp);
    assign w_enter   = ((r_state == IDLE) && bus.START) || (w_advance && !(w_at_last && !r_loop));
    assign w_finish  = w_advance && w_at_last && !r_loop;

    stim_step_ram #(.DEPTH(DEPTH)) u_ram (
        .CLK       (CLK),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (bus.WR_ADDR),
        .i_wr_data (w_wr_step),
        .i_rd_addr (w_nidx),
        .o_rd_data (w_step)
    );

    always_ff @(posedge CLK) begin
        r_done <= 1'b0;
        if (RESET || bus.STOP) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_last   <= '0;
            r_loop   <= 1'b0;
            r_cnt    <= '0;
            r_gap    <= '0;
            r_con_en <= 1'b0;
            r_sent   <= 1'b0;
            r_dip    <= '0;
            r_pb     <= '0;
            r_con    <= 8'h00;
            r_valid  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.START) begin
                        r_loop <= bus.LOOP;
                        r_last <= bus.LAST_STEP;
                    end
                end
                HOLD: begin
                    if (w_xfer) begin
                        r_valid <= 1'b0;
                        r_con   <= 8'h00;
                        r_sent  <= 1'b1;
                    end
                    if (!w_cnt_exp) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_con_ok && (r_gap != '0)) begin
                        r_state <= GAP;
                        r_cnt   <= r_gap;
                        r_dip   <= '0;
                        r_pb    <= '0;
                    end
                end
                GAP: begin
                    if (!w_cnt_exp) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Entering a step overrides the per-state updates above: a new visit re-arms the console byte.
            if (w_enter) begin
                r_state  <= HOLD;
                r_idx    <= w_nidx;
                r_dip    <= w_step.dip;
                r_pb     <= w_step.pb;
                r_cnt    <= hold_load(w_step.hold);
                r_gap    <= w_step.gap;
                r_con_en <= w_step.con_en;
                r_con    <= w_step.con_en ? w_step.con_byte : 8'h00;
                r_valid  <= w_step.con_en;
                r_sent   <= 1'b0;
            end else if (w_finish) begin
                r_state <= IDLE;
                r_idx   <= '0;
                r_dip   <= '0;
                r_pb    <= '0;
                r_con   <= 8'h00;
                r_valid <= 1'b0;
                r_done  <= 1'b1;
            end
        end
    end

    assign bus.DIP              = r_dip;
    assign bus.PB               = r_pb;
    assign bus.CONSOLE_IN       = r_con;
    assign bus.CONSOLE_IN_valid = r_valid;
    assign bus.BUSY             = (r_state != IDLE);
    assign bus.DONE             = r_done;
    assign bus.STEP_IDX         = r_idx;
endmodule

// File: tb/tb_dip_stim_sequencer.sv
// Self-checking bench for dip_stim_sequencer: randomized tables checked against a per-cycle trace model.
module tb_dip_stim_sequencer;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dip_stim_sequencer_if bus ();
    dip_stim_sequencer dut (.CLK(clk), .RESET(rst), .bus(bus));

    int n_total = 0;
    int n_pass  = 0;

    logic [15:0] tdip [DEPTH];
    logic [2:0]  tpb  [DEPTH];
    int          thold[DEPTH];
    int          tgap [DEPTH];

    logic [15:0]   exp_dip[$];
    logic [2:0]    exp_pb [$];
    logic [AW-1:0] exp_idx[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_step(input int a, input logic [15:0] d, input logic [2:0] p, input int h,
                              input int g, input bit ce, input logic [7:0] cb);
        bus.WR_ADDR = a[AW-1:0];
        bus.WR_DIP = d;
        bus.WR_PB = p;
        bus.WR_HOLD = h[15:0];
        bus.WR_GAP = g[15:0];
        bus.WR_CON_EN = ce;
        bus.WR_CON_BYTE = cb;
        bus.WR_EN = 1'b1;
        tick();
        bus.WR_EN = 1'b0;
        tdip[a] = d; tpb[a] = p; thold[a] = h; tgap[a] = g;
    endtask

    task automatic start_run(input int last, input bit loop);
        bus.LAST_STEP = last[AW-1:0];
        bus.LOOP = loop;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        bus.LOOP = 1'($urandom);
        bus.LAST_STEP = AW'($urandom);
    endtask

    // Expected per-cycle stimulus: each step shows its value max(hold,1) cycles, then gap zero cycles.
    function automatic void build_trace(input int last, input bit loop, input int max_len);
        int s = 0;
        exp_dip.delete(); exp_pb.delete(); exp_idx.delete();
        while (exp_dip.size() < max_len) begin
            for (int c = 0; c < ((thold[s] == 0) ? 1 : thold[s]); c++) begin
                exp_dip.push_back(tdip[s]); exp_pb.push_back(tpb[s]); exp_idx.push_back(AW'(s));
            end
            for (int c = 0; c < tgap[s]; c++) begin
                exp_dip.push_back(16'h0); exp_pb.push_back(3'h0); exp_idx.push_back(AW'(s));
            end
            if (s < last) s++;
            else if (loop) s = 0;
            else break;
        end
        while (exp_dip.size() > max_len) begin
            void'(exp_dip.pop_back()); void'(exp_pb.pop_back()); void'(exp_idx.pop_back());
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.START = 1'b1;
            tick();
            n_total++;
            if (bus.DIP !== 16'h0 || bus.PB !== 3'h0 || bus.CONSOLE_IN !== 8'h00 || bus.CONSOLE_IN_valid !== 1'b0 ||
                bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.STEP_IDX !== 3'd0)
                $display("FAIL reset_vals dip=%h pb=%h con=%h vld=%b busy=%b done=%b idx=%0d required all 0",
                         bus.DIP, bus.PB, bus.CONSOLE_IN, bus.CONSOLE_IN_valid, bus.BUSY, bus.DONE, bus.STEP_IDX);
            else n_pass++;
        end
        bus.START = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_one_shot();
        int busy_cnt = 0;
        int done_cnt = 0;
        write_step(0, 16'hC001, 3'd1, 10, 1, 1'b0, 8'h00);
        write_step(1, 16'h8001, 3'd2, 10, 1, 1'b0, 8'h00);
        write_step(2, 16'h4001, 3'd3, 10, 1, 1'b0, 8'h00);
        write_step(3, 16'h0A51, 3'd4, 10, 1, 1'b0, 8'h00);
        write_step(4, 16'h0F53, 3'd5, 10, 1, 1'b0, 8'h00);
        build_trace(4, 1'b0, 1000);
        start_run(4, 1'b0);
        for (int i = 0; i < exp_dip.size(); i++) begin
            busy_cnt += int'(bus.BUSY === 1'b1);
            done_cnt += int'(bus.DONE === 1'b1);
            n_total++;
            if (bus.DIP !== exp_dip[i] || bus.PB !== exp_pb[i] || bus.STEP_IDX !== exp_idx[i])
                $display("FAIL oneshot_trace cyc=%0d dip=%h pb=%h idx=%0d required dip=%h pb=%h idx=%0d",
                         i, bus.DIP, bus.PB, bus.STEP_IDX, exp_dip[i], exp_pb[i], exp_idx[i]);
            else n_pass++;
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            busy_cnt += int'(bus.BUSY === 1'b1);
            done_cnt += int'(bus.DONE === 1'b1);
            if (i == 0) begin
                n_total++;
                if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b1 || bus.DIP !== 16'h0)
                    $display("FAIL oneshot_end busy=%b done=%b dip=%h required busy=0 done=1 dip=0", bus.BUSY, bus.DONE, bus.DIP);
                else n_pass++;
            end
            tick();
        end
        n_total++;
        if (busy_cnt !== 55) $display("FAIL oneshot_busy_len got %0d required 55", busy_cnt);
        else n_pass++;
        n_total++;
        if (done_cnt !== 1) $display("FAIL oneshot_done_count got %0d required 1", done_cnt);
        else n_pass++;
    endtask

    task automatic test_edge_values();
        write_step(0, 16'h1234, 3'd6, 0, 0, 1'b0, 8'h00);
        write_step(1, 16'hBEEF, 3'd7, 2, 1, 1'b0, 8'h00);
        build_trace(1, 1'b0, 1000);
        start_run(1, 1'b0);
        for (int i = 0; i < exp_dip.size(); i++) begin
            n_total++;
            if (bus.DIP !== exp_dip[i] || bus.PB !== exp_pb[i] || bus.STEP_IDX !== exp_idx[i] || bus.BUSY !== 1'b1)
                $display("FAIL edge_trace cyc=%0d dip=%h idx=%0d busy=%b required dip=%h idx=%0d busy=1",
                         i, bus.DIP, bus.STEP_IDX, bus.BUSY, exp_dip[i], exp_idx[i]);
            else n_pass++;
            tick();
        end
        n_total++;
        if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b1)
            $display("FAIL edge_end busy=%b done=%b required busy=0 done=1", bus.BUSY, bus.DONE);
        else n_pass++;
        tick();
    endtask

    task automatic test_random_tables();
        for (int it = 0; it < 4; it++) begin
            int last = $urandom_range(0, DEPTH - 1);
            for (int s = 0; s < DEPTH; s++)
                write_step(s, 16'($urandom), 3'($urandom), $urandom_range(0, 5), $urandom_range(0, 3), 1'b0, 8'h00);
            build_trace(last, 1'b0, 1000);
            start_run(last, 1'b0);
            for (int i = 0; i < exp_dip.size(); i++) begin
                n_total++;
                if (bus.DIP !== exp_dip[i] || bus.PB !== exp_pb[i] || bus.STEP_IDX !== exp_idx[i] ||
                    bus.BUSY !== 1'b1 || bus.DONE !== 1'b0)
                    $display("FAIL rand_trace it=%0d cyc=%0d dip=%h pb=%h idx=%0d busy=%b done=%b required dip=%h pb=%h idx=%0d busy=1 done=0",
                             it, i, bus.DIP, bus.PB, bus.STEP_IDX, bus.BUSY, bus.DONE, exp_dip[i], exp_pb[i], exp_idx[i]);
                else n_pass++;
                tick();
            end
            n_total++;
            if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b1 || bus.STEP_IDX !== 3'd0)
                $display("FAIL rand_end it=%0d busy=%b done=%b idx=%0d required 0/1/0", it, bus.BUSY, bus.DONE, bus.STEP_IDX);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_console();
        logic [15:0] d0 = 16'($urandom) | 16'h0001;
        int hold_cyc = 0;
        int xfers = 0;
        write_step(0, d0, 3'd2, 3, 2, 1'b1, 8'h41);
        bus.CONSOLE_IN_ack = 1'b0;
        start_run(0, 1'b0);
        for (int c = 1; c <= 20 && bus.DIP === d0; c++) begin
            hold_cyc++;
            n_total++;
            if (bus.CONSOLE_IN_valid !== 1'b1 || bus.CONSOLE_IN !== 8'h41)
                $display("FAIL con_valid cyc=%0d vld=%b byte=%h required vld=1 byte=41", c, bus.CONSOLE_IN_valid, bus.CONSOLE_IN);
            else n_pass++;
            bus.CONSOLE_IN_ack = (c == 7);
            if (bus.CONSOLE_IN_valid === 1'b1 && bus.CONSOLE_IN_ack === 1'b1) xfers++;
            tick();
        end
        bus.CONSOLE_IN_ack = 1'b0;
        n_total++;
        if (hold_cyc !== 7) $display("FAIL con_hold_len got %0d required 7", hold_cyc);
        else n_pass++;
        for (int g = 0; g < 3; g++) begin
            if (bus.CONSOLE_IN_valid === 1'b1 && bus.CONSOLE_IN_ack === 1'b1) xfers++;
            n_total++;
            if (bus.CONSOLE_IN_valid !== 1'b0 || bus.DIP !== 16'h0 || bus.BUSY !== (g < 2) || bus.DONE !== (g == 2))
                $display("FAIL con_after g=%0d vld=%b dip=%h busy=%b done=%b required vld=0 dip=0 busy=%b done=%b",
                         g, bus.CONSOLE_IN_valid, bus.DIP, bus.BUSY, bus.DONE, g < 2, g == 2);
            else n_pass++;
            bus.CONSOLE_IN_ack = (g == 0);
            tick();
        end
        bus.CONSOLE_IN_ack = 1'b0;
        n_total++;
        if (xfers !== 1) $display("FAIL con_xfer_count got %0d required 1", xfers);
        else n_pass++;
    endtask

    task automatic test_loop();
        for (int s = 0; s < 3; s++)
            write_step(s, 16'($urandom) | 16'h8000, 3'($urandom), $urandom_range(1, 3), $urandom_range(1, 2), 1'b0, 8'h00);
        build_trace(2, 1'b1, 40);
        start_run(2, 1'b1);
        for (int i = 0; i < exp_dip.size(); i++) begin
            n_total++;
            if (bus.DIP !== exp_dip[i] || bus.STEP_IDX !== exp_idx[i] || bus.BUSY !== 1'b1 || bus.DONE !== 1'b0)
                $display("FAIL loop_trace cyc=%0d dip=%h idx=%0d busy=%b done=%b required dip=%h idx=%0d busy=1 done=0",
                         i, bus.DIP, bus.STEP_IDX, bus.BUSY, bus.DONE, exp_dip[i], exp_idx[i]);
            else n_pass++;
            tick();
        end
        bus.STOP = 1'b1;
        tick();
        bus.STOP = 1'b0;
        n_total++;
        if (bus.DIP !== 16'h0 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.STEP_IDX !== 3'd0)
            $display("FAIL loop_stop dip=%h busy=%b done=%b idx=%0d required all 0", bus.DIP, bus.BUSY, bus.DONE, bus.STEP_IDX);
        else n_pass++;
        tick();
    endtask

    task automatic test_stop_and_busy_writes();
        write_step(0, 16'h5A5A, 3'd1, 5, 1, 1'b1, 8'($urandom));
        write_step(1, 16'h0333, 3'd2, 2, 0, 1'b0, 8'h00);
        start_run(1, 1'b0);
        tick();
        n_total++;
        if (bus.CONSOLE_IN_valid !== 1'b1) $display("FAIL stop_pending vld=%b required 1", bus.CONSOLE_IN_valid);
        else n_pass++;
        bus.STOP = 1'b1;
        bus.START = 1'b1;
        tick();
        bus.STOP = 1'b0;
        bus.START = 1'b0;
        n_total++;
        if (bus.CONSOLE_IN_valid !== 1'b0 || bus.BUSY !== 1'b0 || bus.DIP !== 16'h0)
            $display("FAIL stop_drop vld=%b busy=%b dip=%h required 0/0/0", bus.CONSOLE_IN_valid, bus.BUSY, bus.DIP);
        else n_pass++;
        bus.CONSOLE_IN_ack = 1'b1;
        tick();
        bus.CONSOLE_IN_ack = 1'b0;
        tick();
        n_total++;
        if (bus.CONSOLE_IN_valid !== 1'b0 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.CONSOLE_IN !== 8'h00)
            $display("FAIL stop_late_ack vld=%b busy=%b done=%b con=%h required 0/0/0/00",
                     bus.CONSOLE_IN_valid, bus.BUSY, bus.DONE, bus.CONSOLE_IN);
        else n_pass++;
        write_step(0, 16'h5A5A, 3'd1, 4, 1, 1'b0, 8'h00);
        build_trace(1, 1'b0, 1000);
        for (int r = 0; r < 2; r++) begin
            start_run(1, 1'b0);
            for (int i = 0; i < exp_dip.size(); i++) begin
                n_total++;
                if (bus.DIP !== exp_dip[i] || bus.STEP_IDX !== exp_idx[i] || bus.BUSY !== 1'b1)
                    $display("FAIL busy_ignore r=%0d cyc=%0d dip=%h idx=%0d busy=%b required dip=%h idx=%0d busy=1",
                             r, i, bus.DIP, bus.STEP_IDX, bus.BUSY, exp_dip[i], exp_idx[i]);
                else n_pass++;
                bus.START = (r == 0 && (i == 2 || i == 6));
                bus.WR_EN = (r == 0 && i >= 2 && i <= 4);
                bus.WR_ADDR = AW'(i - 2);
                bus.WR_DIP = 16'hDEAD;
                bus.WR_HOLD = 16'd9;
                bus.WR_GAP = 16'd0;
                tick();
            end
            bus.START = 1'b0;
            bus.WR_EN = 1'b0;
            n_total++;
            if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b1)
                $display("FAIL busy_ignore_end r=%0d busy=%b done=%b required 0/1", r, bus.BUSY, bus.DONE);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_reset_mid_hold();
        build_trace(1, 1'b0, 1000);
        start_run(1, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++;
        if (bus.DIP !== 16'h0 || bus.PB !== 3'h0 || bus.CONSOLE_IN !== 8'h00 || bus.CONSOLE_IN_valid !== 1'b0 ||
            bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.STEP_IDX !== 3'd0)
            $display("FAIL reset_mid dip=%h pb=%h con=%h vld=%b busy=%b done=%b idx=%0d required all 0",
                     bus.DIP, bus.PB, bus.CONSOLE_IN, bus.CONSOLE_IN_valid, bus.BUSY, bus.DONE, bus.STEP_IDX);
        else n_pass++;
        tick();
        start_run(1, 1'b0);
        for (int i = 0; i < exp_dip.size(); i++) begin
            n_total++;
            if (bus.DIP !== exp_dip[i] || bus.PB !== exp_pb[i] || bus.STEP_IDX !== exp_idx[i])
                $display("FAIL reset_replay cyc=%0d dip=%h pb=%h idx=%0d required dip=%h pb=%h idx=%0d",
                         i, bus.DIP, bus.PB, bus.STEP_IDX, exp_dip[i], exp_pb[i], exp_idx[i]);
            else n_pass++;
            tick();
        end
        n_total++;
        if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b1)
            $display("FAIL reset_replay_end busy=%b done=%b required 0/1", bus.BUSY, bus.DONE);
        else n_pass++;
        tick();
    endtask

    initial begin
        bus.START = 1'b0; bus.STOP = 1'b0; bus.LOOP = 1'b0; bus.LAST_STEP = '0;
        bus.WR_EN = 1'b0; bus.WR_ADDR = '0; bus.WR_DIP = '0; bus.WR_PB = '0;
        bus.WR_HOLD = '0; bus.WR_GAP = '0; bus.WR_CON_EN = 1'b0; bus.WR_CON_BYTE = '0;
        bus.CONSOLE_IN_ack = 1'b0;
        test_reset();
        test_one_shot();
        test_edge_values();
        test_random_tables();
        test_console();
        test_loop();
        test_stop_and_busy_writes();
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
